mem_access_unit: RTL and testbench
==================================

# mem_access_unit

MEM-stage load/store unit of the 5-stage CPU, sitting between the EX/MEM pipeline register and the MEM/WB register. It consumes the EX/MEM control, ALU address and store data, runs a req/ack transaction on the data-memory port, and stalls the pipeline until that transaction completes. It also generates byte enables and lane-replicated write data for stores, and sign/zero-extends load data for writeback.

## Interface
Parameters:
- DATA_WIDTH, 32, data path width; only 32 is supported.
- ADDR_WIDTH, 12, number of byte-address bits decoded. The memory word address is ADDR_WIDTH-2 bits wide.

Ports:
- clk  in  1  clock.
- i_rst  in  1  synchronous, active-high reset.
- i_valid  in  1  EX/MEM holds a live instruction.
- i_mem_read  in  1  instruction is a load.
- i_mem_write  in  1  instruction is a store.
- i_funct3  in  3  access size: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- i_addr  in  DATA_WIDTH  byte address (ALU result).
- i_store_data  in  DATA_WIDTH  store source (rs2).
- o_dmem_req  out  1  memory request.
- o_dmem_we  out  1  write request (1) or read request (0).
- o_dmem_addr  out  ADDR_WIDTH-2  word address.
- o_dmem_be  out  4  byte enables.
- o_dmem_wdata  out  DATA_WIDTH  lane-replicated write data.
- i_dmem_rdata  in  DATA_WIDTH  read word; valid only while i_dmem_ack is high.
- i_dmem_ack  in  1  transaction complete.
- o_stall  out  1  hold PC, IF/ID, ID/EX and EX/MEM; MEM/WB does not capture.
- o_load_data  out  DATA_WIDTH  formatted load result, registered.
- o_load_valid  out  1  o_load_data is valid for the instruction leaving MEM this cycle.
- o_fault  out  1  misaligned or illegal access; combinational, asserted in IDLE only.

## Operation
- An access is present when i_valid & (i_mem_read | i_mem_write).
- The access is faulting in any of these cases:
  - both i_mem_read and i_mem_write are high;
  - i_funct3 is 011, 110 or 111;
  - H/HU with i_addr[0]=1;
  - W with i_addr[1:0]≠00.
- A faulting access gives o_fault=1, no request and no stall. The instruction leaves with o_load_valid=0.
- The FSM has three states: IDLE, BUSY, DONE.
- IDLE:
  - No access present: o_stall=0; the instruction passes through.
  - Non-faulting access present: o_stall=1. At the clock edge, register req=1, we, addr=i_addr[ADDR_WIDTH-1:2], be and wdata, then go to BUSY.
- BUSY:
  - o_stall=1, and req/we/addr/be/wdata are held stable.
  - On i_dmem_ack: for loads, register the formatted i_dmem_rdata into o_load_data. Clear req and go to DONE.
  - With no ack, the FSM stays in BUSY indefinitely.
- DONE:
  - o_stall=0 and o_load_valid = (the access was a load).
  - Go to IDLE unconditionally, so the same EX/MEM contents never re-trigger an access.
- Store formatting:
  - SB: be=0001<<addr[1:0]; wdata={4{byte0}}.
  - SH: be=0011 when addr[1]=0, 1100 when addr[1]=1; wdata={2{half0}}.
  - SW: be=1111; wdata=store data.
- Load formatting:
  - Select the byte or halfword using addr[1:0], as registered at request time.
  - B/H sign-extend; BU/HU zero-extend; W passes through unchanged.
- Address bits above ADDR_WIDTH-1 are ignored; there is no range fault.
- Loads issue with be=1111.

## Timing
- Reset values:
  - FSM = IDLE.
  - o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_be, o_dmem_wdata, o_load_data and o_load_valid = 0.
  - o_stall and o_fault are reset-independent combinational functions of the IDLE state and the inputs.
- Memory contract: ack comes no earlier than the first BUSY cycle. An ack seen outside BUSY is ignored.
- Minimum latency with ack in the first BUSY cycle:
  - cycle 0: IDLE, stall.
  - cycle 1: BUSY, ack, stall.
  - cycle 2: DONE, no stall.
  - This gives 2 stall cycles per memory access; each extra cycle of ack delay adds one stall cycle.
- o_load_data keeps its last value until the next completed load.
- Reset mid-transaction (BUSY or DONE):
  - Go to IDLE and drop req in the same edge.
  - Any later ack for the abandoned transaction is ignored.
  - o_load_data clears to 0.
- Back-to-back accesses: the next access is detected in the IDLE cycle following DONE. There is no bubble beyond the FSM's own 3 cycles.

## Test plan
- SW: addr=0x104, data=0xDEADBEEF, ack delay 0. Required response:
  - req high for cycles 1..1, we=1, be=1111, word addr=0x41, wdata=0xDEADBEEF;
  - o_stall=1,1,0 over cycles 0..2;
  - o_load_valid stays 0.
- SB: addr=0x0003, data=0x000000A5. Required response: be=1000, wdata=0xA5A5A5A5.
- SH: addr=0x0002, data=0x1234. Required response: be=1100, wdata=0x12341234.
- Loads from word 0x80FF7F01, each with ack delay 3. Required response: stall lasts 5 cycles; o_load_data in DONE:
  - LB @+1 → 0x0000007F;
  - LB @+3 → 0xFFFFFF80;
  - LBU @+3 → 0x00000080;
  - LH @+2 → 0xFFFF80FF;
  - LHU @+2 → 0x000080FF;
  - LW → 0x80FF7F01.
- Faults:
  - LW @0x102 → o_fault=1, no req, no stall, o_load_valid=0.
  - LH @0x101 → o_fault=1, no req, no stall, o_load_valid=0.
  - funct3=011 → o_fault=1, no req, no stall, o_load_valid=0.
  - read and write both high → o_fault=1, no req, no stall, o_load_valid=0.
- Reset in BUSY, with ack delayed 2 cycles: i_rst in the first BUSY cycle, then ack arrives → required response: FSM in IDLE, req=0, o_load_data=0, ack ignored. With i_valid=0 after reset, o_stall=0.

Source files
------------

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: runs one req/ack data-memory transaction per load
// or store, stalls the pipeline until it completes, and formats store/load data.
module mem_access_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  input  logic                  i_mem_read,
  input  logic                  i_mem_write,
  input  logic [2:0]            i_funct3,
  input  logic [DATA_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_store_data,
  output logic                  o_dmem_req,
  output logic                  o_dmem_we,
  output logic [ADDR_WIDTH-3:0] o_dmem_addr,
  output logic [3:0]            o_dmem_be,
  output logic [DATA_WIDTH-1:0] o_dmem_wdata,
  input  logic [DATA_WIDTH-1:0] i_dmem_rdata,
  input  logic                  i_dmem_ack,
  output logic                  o_stall,
  output logic [DATA_WIDTH-1:0] o_load_data,
  output logic                  o_load_valid,
  output logic                  o_fault
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic                  w_access;
  logic                  w_bad_funct3;
  logic                  w_misaligned;
  logic                  w_fault_cond;
  logic                  w_start;
  logic [3:0]            w_be;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [DATA_WIDTH-1:0] w_rdata_shift;
  logic [DATA_WIDTH-1:0] w_load_fmt;
  logic                  w_unused_addr_hi;

  logic                  r_req;
  logic                  r_we;
  logic [ADDR_WIDTH-3:0] r_addr;
  logic [3:0]            r_be;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [2:0]            r_funct3;
  logic [1:0]            r_off;
  logic                  r_is_load;
  logic [DATA_WIDTH-1:0] r_load_data;

  // Byte-address bits above the decoded range are deliberately ignored.
  assign w_unused_addr_hi = ^i_addr[DATA_WIDTH-1:ADDR_WIDTH];

  assign w_access = i_valid & (i_mem_read | i_mem_write);

  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    w_bad_funct3 = 1'b0;
    w_misaligned = 1'b0;
    case (i_funct3)
      3'b011, 3'b110, 3'b111: w_bad_funct3 = 1'b1;
      3'b001, 3'b101:         w_misaligned = i_addr[0];
      3'b010:                 w_misaligned = |i_addr[1:0];
      default: ;
    endcase
  end

  assign w_fault_cond = (i_mem_read & i_mem_write) | w_bad_funct3 | w_misaligned;
  assign w_start      = (r_state == S_IDLE) & w_access & ~w_fault_cond;

  // Stores replicate the source across all lanes; the byte enables pick the lane.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = '0;
    if (i_mem_write) begin
      case (i_funct3[1:0])
        2'b00: begin
          w_be    = 4'b0001 << i_addr[1:0];
          w_wdata = {4{i_store_data[7:0]}};
        end
        2'b01: begin
          w_be    = i_addr[1] ? 4'b1100 : 4'b0011;
          w_wdata = {2{i_store_data[15:0]}};
        end
        default: w_wdata = i_store_data;
      endcase
    end
  end

  // Load lane selection uses the byte offset captured when the request went out.
  assign w_rdata_shift = i_dmem_rdata >> {r_off, 3'b000};

  always_comb begin
    case (r_funct3)
      3'b000:  w_load_fmt = {{(DATA_WIDTH-8){w_rdata_shift[7]}},   w_rdata_shift[7:0]};
      3'b100:  w_load_fmt = {{(DATA_WIDTH-8){1'b0}},               w_rdata_shift[7:0]};
      3'b001:  w_load_fmt = {{(DATA_WIDTH-16){w_rdata_shift[15]}}, w_rdata_shift[15:0]};
      3'b101:  w_load_fmt = {{(DATA_WIDTH-16){1'b0}},              w_rdata_shift[15:0]};
      default: w_load_fmt = i_dmem_rdata;
    endcase
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_next_state = S_BUSY;
      S_BUSY:  if (i_dmem_ack) w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_req       <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_be        <= '0;
      r_wdata     <= '0;
      r_funct3    <= '0;
      r_off       <= '0;
      r_is_load   <= 1'b0;
      r_load_data <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_req     <= 1'b1;
            r_we      <= i_mem_write;
            r_addr    <= i_addr[ADDR_WIDTH-1:2];
            r_be      <= w_be;
            r_wdata   <= w_wdata;
            r_funct3  <= i_funct3;
            r_off     <= i_addr[1:0];
            r_is_load <= i_mem_read;
          end
        end
        S_BUSY: begin
          if (i_dmem_ack) begin
            r_req <= 1'b0;
            if (r_is_load) r_load_data <= w_load_fmt;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_dmem_req   = r_req;
  assign o_dmem_we    = r_we;
  assign o_dmem_addr  = r_addr;
  assign o_dmem_be    = r_be;
  assign o_dmem_wdata = r_wdata;
  assign o_load_data  = r_load_data;
  assign o_load_valid = (r_state == S_DONE) & r_is_load;
  assign o_stall      = w_start | (r_state == S_BUSY);
  assign o_fault      = (r_state == S_IDLE) & w_access & w_fault_cond;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: the driver queues expected events from
// a behavioural model; a negedge monitor pops and compares them.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic        i_mem_read;
  logic        i_mem_write;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr;
  logic [31:0] i_store_data;
  logic        o_dmem_req;
  logic        o_dmem_we;
  logic [9:0]  o_dmem_addr;
  logic [3:0]  o_dmem_be;
  logic [31:0] o_dmem_wdata;
  logic [31:0] i_dmem_rdata;
  logic        i_dmem_ack;
  logic        o_stall;
  logic [31:0] o_load_data;
  logic        o_load_valid;
  logic        o_fault;

  mem_access_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) dut (
    .clk          (clk),
    .i_rst        (i_rst),
    .i_valid      (i_valid),
    .i_mem_read   (i_mem_read),
    .i_mem_write  (i_mem_write),
    .i_funct3     (i_funct3),
    .i_addr       (i_addr),
    .i_store_data (i_store_data),
    .o_dmem_req   (o_dmem_req),
    .o_dmem_we    (o_dmem_we),
    .o_dmem_addr  (o_dmem_addr),
    .o_dmem_be    (o_dmem_be),
    .o_dmem_wdata (o_dmem_wdata),
    .i_dmem_rdata (i_dmem_rdata),
    .i_dmem_ack   (i_dmem_ack),
    .o_stall      (o_stall),
    .o_load_data  (o_load_data),
    .o_load_valid (o_load_valid),
    .o_fault      (o_fault)
  );

  always #5 clk = ~clk;

  typedef enum logic [1:0] {K_FAULT = 2'd0, K_STORE = 2'd1, K_LOAD = 2'd2} kind_e;

  typedef struct {
    kind_e       kind;
    logic        we;
    logic [9:0]  waddr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] ldata;
    int          stall;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
  endtask

  // ---------------- reference model ----------------
  function automatic bit is_fault(input bit rd, input bit wr, input logic [2:0] f3,
                                  input logic [31:0] a);
    if (rd && wr) return 1'b1;
    if (f3 == 3 || f3 == 6 || f3 == 7) return 1'b1;
    if ((f3 == 1 || f3 == 5) && a[0]) return 1'b1;
    if (f3 == 2 && (a % 4) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] load_fmt(input logic [31:0] w, input logic [2:0] f3,
                                           input int off);
    int unsigned v;
    v = w >> (8 * off);
    case (f3)
      3'd0: begin v = v % 256;   if (v >= 128)   v = v + 32'hFFFF_FF00; end
      3'd4:       v = v % 256;
      3'd1: begin v = v % 65536; if (v >= 32768) v = v + 32'hFFFF_0000; end
      3'd5:       v = v % 65536;
      default:    v = w;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] f3, input int off);
    if (f3 == 0) return 4'(1 << off);
    if (f3 == 1) return (off >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] d);
    if (f3 == 0) return (d % 256) * 32'h0101_0101;
    if (f3 == 1) return (d % 65536) * 32'h0001_0001;
    return d;
  endfunction

  // ---------------- driver ----------------
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      i_valid      = 1'($urandom_range(0, 1));
      i_mem_read   = 1'b0;
      i_mem_write  = 1'b0;
      i_funct3     = 3'($urandom);
      i_addr       = $urandom;
      i_store_data = $urandom;
      i_dmem_ack   = 1'($urandom_range(0, 1));
      i_dmem_rdata = $urandom;
      @(posedge clk); #1;
    end
    i_valid    = 1'b0;
    i_dmem_ack = 1'b0;
  endtask

  task automatic run_txn(input bit rd, input bit wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sdata,
                         input logic [31:0] rword, input int delay);
    exp_t e;
    bit   flt;
    flt     = is_fault(rd, wr, f3, a);
    e.kind  = flt ? K_FAULT : (wr ? K_STORE : K_LOAD);
    e.we    = wr;
    e.waddr = 10'((a % 4096) / 4);
    e.be    = wr ? store_be(f3, a % 4) : 4'hF;
    e.wdata = store_wdata(f3, sdata);
    e.ldata = load_fmt(rword, f3, a % 4);
    e.stall = 2 + delay;
    exp_q.push_back(e);

    i_valid      = 1'b1;
    i_mem_read   = rd;
    i_mem_write  = wr;
    i_funct3     = f3;
    i_addr       = a;
    i_store_data = sdata;
    i_dmem_ack   = 1'b0;
    i_dmem_rdata = $urandom;
    @(posedge clk); #1;
    if (!flt) begin
      for (int i = 0; i < delay; i++) begin
        i_dmem_rdata = $urandom;
        @(posedge clk); #1;
      end
      i_dmem_ack   = 1'b1;
      i_dmem_rdata = rword;
      @(posedge clk); #1;
      i_dmem_ack   = 1'b0;
      i_dmem_rdata = $urandom;
      @(posedge clk); #1;
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [31:0] last_load = '0;

  initial begin
    exp_t cur;
    exp_t e;
    bit   have_cur = 1'b0;
    bit   prev_req = 1'b0;
    bit   rst_prev = 1'b1;
    bit   done_now;
    int   stall_run = 0;
    forever begin
      @(negedge clk);
      if (i_rst || rst_prev) begin
        have_cur  = 1'b0;
        stall_run = 0;
        last_load = '0;
      end else begin
        done_now = 1'b0;
        if (o_stall) stall_run++;

        if (o_fault) begin
          if (exp_q.size() == 0) check("unexpected_fault", exp_q.size(), 1);
          else begin
            e = exp_q.pop_front();
            check("fault_event_kind", o_fault ? K_FAULT : K_LOAD, e.kind);
            check("fault_stall", o_stall, 0);
            check("fault_req", o_dmem_req, 0);
            check("fault_load_valid", o_load_valid, 0);
          end
        end

        if (o_dmem_req && !prev_req) begin
          if (exp_q.size() == 0) check("unexpected_req", exp_q.size(), 1);
          else begin
            cur      = exp_q.pop_front();
            have_cur = 1'b1;
            check("req_not_fault", (cur.kind == K_FAULT), 0);
          end
        end

        if (o_dmem_req && have_cur) begin
          check("req_we", o_dmem_we, cur.we);
          check("req_addr", o_dmem_addr, cur.waddr);
          check("req_be", o_dmem_be, cur.be);
          if (cur.kind == K_STORE) check("req_wdata", o_dmem_wdata, cur.wdata);
          check("req_stall", o_stall, 1);
        end

        if (!o_dmem_req && prev_req && have_cur) begin
          done_now = 1'b1;
          check("done_load_valid", o_load_valid, (cur.kind == K_LOAD));
          if (cur.kind == K_LOAD) last_load = cur.ldata;
          check("done_load_data", o_load_data, last_load);
          check("done_stall", o_stall, 0);
          check("stall_cycles", stall_run, cur.stall);
          have_cur = 1'b0;
        end

        if (o_load_valid && !done_now) check("spurious_load_valid", o_load_valid, 0);
        if (!o_stall) stall_run = 0;
      end
      prev_req = o_dmem_req;
      rst_prev = i_rst;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  logic [2:0] ld_f3 [12] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6};
  logic [2:0] st_f3 [8]  = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd1, 3'd2, 3'd3, 3'd7};

  initial begin
    i_rst = 1'b1; i_valid = 1'b0; i_mem_read = 1'b0; i_mem_write = 1'b0;
    i_funct3 = '0; i_addr = '0; i_store_data = '0; i_dmem_ack = 1'b0; i_dmem_rdata = '0;
    repeat (3) @(posedge clk);
    #1 i_rst = 1'b0;
    @(negedge clk);
    check("rst_req", o_dmem_req, 0);
    check("rst_we", o_dmem_we, 0);
    check("rst_addr", o_dmem_addr, 0);
    check("rst_be", o_dmem_be, 0);
    check("rst_wdata", o_dmem_wdata, 0);
    check("rst_load_data", o_load_data, 0);
    check("rst_load_valid", o_load_valid, 0);
    check("rst_stall", o_stall, 0);
    check("rst_fault", o_fault, 0);
    @(posedge clk); #1;

    // directed stores
    run_txn(0, 1, 3'd2, 32'h0000_0104, 32'hDEAD_BEEF, 32'h0, 0);
    run_txn(0, 1, 3'd0, 32'h0000_0003, 32'h0000_00A5, 32'h0, 1);
    run_txn(0, 1, 3'd1, 32'h0000_0002, 32'h0000_1234, 32'h0, 2);
    idle(2);
    // directed loads from word 0x80FF7F01, ack delay 3
    run_txn(1, 0, 3'd0, 32'h0000_0201, 32'h0, 32'h80FF_7F01, 3);
    run_txn(1, 0, 3'd0, 32'h0000_0203, 32'h0, 32'h80FF_7F01, 3);
    run_txn(1, 0, 3'd4, 32'h0000_0203, 32'h0, 32'h80FF_7F01, 3);
    run_txn(1, 0, 3'd1, 32'h0000_0202, 32'h0, 32'h80FF_7F01, 3);
    run_txn(1, 0, 3'd5, 32'h0000_0202, 32'h0, 32'h80FF_7F01, 3);
    run_txn(1, 0, 3'd2, 32'h0000_0200, 32'h0, 32'h80FF_7F01, 3);
    // directed faults
    run_txn(1, 0, 3'd2, 32'h0000_0102, 32'h0, 32'h0, 0);
    run_txn(1, 0, 3'd1, 32'h0000_0101, 32'h0, 32'h0, 0);
    run_txn(1, 0, 3'd3, 32'h0000_0100, 32'h0, 32'h0, 0);
    run_txn(1, 1, 3'd2, 32'h0000_0100, 32'h0, 32'h0, 0);
    idle(1);

    // reset in the first BUSY cycle of a load; its ack arrives later
    i_valid = 1'b1; i_mem_read = 1'b1; i_mem_write = 1'b0;
    i_funct3 = 3'd2; i_addr = 32'h0000_0300;
    @(posedge clk); #1;
    i_rst = 1'b1;
    @(posedge clk); #1;
    i_rst = 1'b0; i_valid = 1'b0; i_mem_read = 1'b0;
    @(negedge clk);
    check("rstbusy_req", o_dmem_req, 0);
    check("rstbusy_load_data", o_load_data, 0);
    check("rstbusy_stall", o_stall, 0);
    @(posedge clk); #1;
    i_dmem_ack = 1'b1; i_dmem_rdata = 32'h1357_9BDF;
    @(negedge clk);
    check("late_ack_stall", o_stall, 0);
    @(posedge clk); #1;
    i_dmem_ack = 1'b0;
    @(negedge clk);
    check("late_ack_req", o_dmem_req, 0);
    check("late_ack_load_valid", o_load_valid, 0);
    check("late_ack_load_data", o_load_data, 0);
    @(posedge clk); #1;

    // randomized traffic
    for (int n = 0; n < 160; n++) begin
      int          op;
      bit          rd;
      bit          wr;
      logic [2:0]  f3;
      logic [31:0] a;
      op = $urandom_range(0, 19);
      rd = (op < 10) || (op == 19);
      wr = (op >= 10);
      f3 = rd && !wr ? ld_f3[$urandom_range(0, 11)] : st_f3[$urandom_range(0, 7)];
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (f3 == 1 || f3 == 5) a[0] = 1'b0;
        if (f3 == 2) a[1:0] = 2'b00;
      end
      run_txn(rd, wr, f3, a, $urandom, $urandom, $urandom_range(0, 4));
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    idle(3);

    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
